// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the BCD 7-segment display stage.
// Segment patterns are active-low, bit order {dp,g,f,e,d,c,b,a}, dp bit idle (1).
package bcd_disp_pkg;

  localparam logic SEG_ACTIVE_LOW = 1'b1;
  localparam logic SEG_ON         = ~SEG_ACTIVE_LOW;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_ERR   = 8'h86;

  // Non-decimal codes (10..15) render as "E".
  function automatic logic [7:0] digit_to_seg(input logic [3:0] code);
    logic [7:0] seg;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_ERR;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sseg_decode.sv
// Combinational glyph decoder for one display position.
//   code_i  : BCD digit code
//   blank_i : position suppressed (leading zero)
//   minus_i : position shows the minus sign (overrides blank)
//   dp_i    : light the decimal point (ignored when blank/minus)
//   seg_o   : active-low {dp,g,f,e,d,c,b,a}
module sseg_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       blank_i,
  input  logic       minus_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = digit_to_seg(code_i);
    if (dp_i)    seg_o[7] = SEG_ON;
    if (blank_i) seg_o    = SEG_BLANK;
    if (minus_i) seg_o    = SEG_MINUS;
  end

endmodule

// File: rtl/bcd_sseg_mux.sv
// Multiplexed common-anode 7-segment driver fed by a BCD converter.
// Shadows the converter result on load, blanks leading zeros, places the
// minus sign, and scans one digit per 2**DIV_W clocks.
//   clk, reset : clock, async active-high reset
//   load       : capture strobe for bcd/sign/dp_idx/dp_en
//   bcd        : packed digits, digit 0 in [3:0]
//   sign       : 1 = negative
//   dp_idx     : decimal point position, dp_en enables it
//   blank      : all anodes off (scan keeps running)
//   an         : active-low anode enables
//   sseg       : active-low segments {dp,g,f,e,d,c,b,a}
//   sign_led   : latched sign
module bcd_sseg_mux
  import bcd_disp_pkg::*;
#(
  parameter int unsigned BCD_N = 4,
  parameter int unsigned DIV_W = 16,
  localparam int unsigned IDX_W = (BCD_N > 1) ? $clog2(BCD_N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [BCD_N*4-1:0] bcd,
  input  logic               sign,
  input  logic [IDX_W-1:0]   dp_idx,
  input  logic               dp_en,
  input  logic               blank,
  output logic [BCD_N-1:0]   an,
  output logic [7:0]         sseg,
  output logic               sign_led
);

  logic [BCD_N*4-1:0] bcd_q;
  logic               sign_q;
  logic [IDX_W-1:0]   dp_idx_q;
  logic               dp_en_q;
  logic [DIV_W-1:0]   cnt_q,  cnt_d;
  logic [IDX_W-1:0]   idx_q,  idx_d;
  logic [BCD_N-1:0]   an_q,   an_d;
  logic [7:0]         sseg_q, sseg_d;

  logic               dp_valid;
  logic [31:0]        dp_eff;
  logic               zero_run;
  logic [BCD_N-1:0]   blank_vec;
  logic [BCD_N-1:0]   minus_vec;
  logic [3:0]         cur_code;
  logic               cur_dp;
  logic [7:0]         dec_seg;

  // Blanking covers the contiguous run of zero digits above both the most
  // significant nonzero digit and the decimal point; an out-of-range dp_idx
  // behaves like position 0 for blanking and shows no point.
  always_comb begin
    dp_valid  = (32'(dp_idx_q) < BCD_N);
    dp_eff    = dp_valid ? 32'(dp_idx_q) : 32'd0;
    zero_run  = 1'b1;
    blank_vec = '0;
    for (int unsigned i = 0; i < BCD_N; i++) begin
      zero_run = zero_run && (bcd_q[(BCD_N-1-i)*4 +: 4] == 4'd0);
      blank_vec[BCD_N-1-i] = zero_run && ((BCD_N-1-i) > dp_eff);
    end
    // Minus sits on the lowest blanked position; digit 0 is never blanked.
    minus_vec = '0;
    for (int unsigned i = 1; i < BCD_N; i++) begin
      minus_vec[i] = sign_q && blank_vec[i] && !blank_vec[i-1];
    end
  end

  always_comb begin
    cur_code = bcd_q[{idx_q, 2'b00} +: 4];
    cur_dp   = dp_en_q && dp_valid && (idx_q == dp_idx_q);
  end

  sseg_decode u_decode (
    .code_i  (cur_code),
    .blank_i (blank_vec[idx_q]),
    .minus_i (minus_vec[idx_q]),
    .dp_i    (cur_dp),
    .seg_o   (dec_seg)
  );

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == '1) begin
      idx_d = (idx_q == IDX_W'(BCD_N - 1)) ? '0 : idx_q + 1'b1;
    end
    an_d = '1;
    if (!blank) an_d[idx_q] = 1'b0;
    sseg_d = blank ? SEG_BLANK : dec_seg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_q    <= '0;
      sign_q   <= 1'b0;
      dp_idx_q <= '0;
      dp_en_q  <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      an_q     <= '1;
      sseg_q   <= SEG_BLANK;
    end else begin
      if (load) begin
        bcd_q    <= bcd;
        sign_q   <= sign;
        dp_idx_q <= dp_idx;
        dp_en_q  <= dp_en;
      end
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      sseg_q <= sseg_d;
    end
  end

  assign an       = an_q;
  assign sseg     = sseg_q;
  assign sign_led = sign_q;

endmodule
